// File: rtl/core_types_pkg.sv
// Shared front-end types: RAS geometry and the fetch checkpoint record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_types_pkg;

    localparam int RAS_ENTRIES      = 8;
    localparam int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
    localparam int RAS_COUNT_WIDTH  = RAS_INDEX_WIDTH + 1;
    localparam int RAS_TARGET_WIDTH = 31;   // PC[31:1]

    // Snapshot that fetch takes on every predicted branch and hands back on a mispredict.
    typedef struct packed {
        logic [RAS_INDEX_WIDTH-1:0] ptr;
        logic [RAS_COUNT_WIDTH-1:0] count;
    } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt.sv
// Return address stack with checkpoint/restore of top pointer and occupancy.
// Latency: reads are combinational from registered state; updates take effect next edge.
// Backpressure: none - every push/pop/restore is accepted in the cycle it is asserted.
//
// Ports:
//   CLK, RST                      clock, async active-high reset
//   push_valid_in/push_target_in  call: push a return target
//   pop_valid_in                  return: pop the top
//   restore_valid_in/_ptr_in/_count_in  mispredict: reload pointer and occupancy
//   ret_target_out/ret_valid_out  predicted return target, stack non-empty
//   ptr_out/count_out             checkpoint source
//   overflow_out                  registered pulse: a push overwrote the oldest live entry
module ras_ckpt #(
    parameter int RAS_ENTRIES      = core_types_pkg::RAS_ENTRIES,
    parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int RAS_COUNT_WIDTH  = RAS_INDEX_WIDTH + 1,
    parameter int RAS_TARGET_WIDTH = core_types_pkg::RAS_TARGET_WIDTH
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        push_valid_in,
    input  logic [RAS_TARGET_WIDTH-1:0] push_target_in,
    input  logic                        pop_valid_in,
    input  logic                        restore_valid_in,
    input  logic [RAS_INDEX_WIDTH-1:0]  restore_ptr_in,
    input  logic [RAS_COUNT_WIDTH-1:0]  restore_count_in,
    output logic [RAS_TARGET_WIDTH-1:0] ret_target_out,
    output logic                        ret_valid_out,
    output logic [RAS_INDEX_WIDTH-1:0]  ptr_out,
    output logic [RAS_COUNT_WIDTH-1:0]  count_out,
    output logic                        overflow_out
);

    localparam logic [RAS_COUNT_WIDTH-1:0] FULL_CNT = RAS_COUNT_WIDTH'(RAS_ENTRIES);
    localparam logic [RAS_INDEX_WIDTH-1:0] ONE_IDX  = RAS_INDEX_WIDTH'(1);
    localparam logic [RAS_COUNT_WIDTH-1:0] ONE_CNT  = RAS_COUNT_WIDTH'(1);

    logic [RAS_INDEX_WIDTH-1:0]  ptr_q, ptr_d;
    logic [RAS_COUNT_WIDTH-1:0]  count_q, count_d;
    logic                        overflow_q, overflow_d;
    logic [RAS_TARGET_WIDTH-1:0] entry_q [RAS_ENTRIES];
    logic [RAS_TARGET_WIDTH-1:0] entry_d [RAS_ENTRIES];
    logic                        wr_en;
    logic [RAS_INDEX_WIDTH-1:0]  wr_idx;
    logic                        empty, full;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    always_comb begin
        ptr_d      = ptr_q;
        count_d    = count_q;
        overflow_d = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = ptr_q;
        if (restore_valid_in) begin
            // Checkpoint counts wider than the stack are clamped; entries are left alone.
            ptr_d   = restore_ptr_in;
            count_d = (restore_count_in > FULL_CNT) ? FULL_CNT : restore_count_in;
        end else if (push_valid_in && pop_valid_in) begin
            // Coroutine jump: replace the top in place.
            wr_en  = 1'b1;
            wr_idx = ptr_q;
            if (empty) begin
                count_d = ONE_CNT;
            end
        end else if (push_valid_in) begin
            ptr_d  = ptr_q + ONE_IDX;
            wr_en  = 1'b1;
            wr_idx = ptr_q + ONE_IDX;
            if (full) begin
                overflow_d = 1'b1;   // ring wrapped onto the oldest live entry
            end else begin
                count_d = count_q + ONE_CNT;
            end
        end else if (pop_valid_in) begin
            // Underflow still moves the pointer so the stale entry serves as a guess.
            ptr_d = ptr_q - ONE_IDX;
            if (!empty) begin
                count_d = count_q - ONE_CNT;
            end
        end
    end

    always_comb begin
        entry_d = entry_q;
        if (wr_en) begin
            entry_d[wr_idx] = push_target_in;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            entry_q    <= entry_d;
        end
    end

    assign ret_target_out = entry_q[ptr_q];
    assign ret_valid_out  = !empty;
    assign ptr_out        = ptr_q;
    assign count_out      = count_q;
    assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_ras_ckpt.sv
// Bench for ras_ckpt: depth-8 and depth-16 instances driven in parallel against a
// behavioural stack model, plus directed scenarios with literal expectations.
module tb_ras_ckpt;
    import core_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        push_v = 1'b0;
    logic [30:0] push_t = '0;
    logic        pop_v = 1'b0;
    logic        rs_v = 1'b0;
    logic [3:0]  rs_ptr = '0;
    logic [4:0]  rs_cnt = '0;
    bit          chk_en = 1'b0;

    logic [30:0] a_tgt, b_tgt;
    logic        a_vld, b_vld, a_ovf, b_ovf;
    logic [2:0]  a_ptr;
    logic [3:0]  a_cnt, b_ptr;
    logic [4:0]  b_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    ras_ckpt dut_a (
        .CLK(CLK), .RST(RST),
        .push_valid_in(push_v), .push_target_in(push_t), .pop_valid_in(pop_v),
        .restore_valid_in(rs_v), .restore_ptr_in(rs_ptr[2:0]), .restore_count_in(rs_cnt[3:0]),
        .ret_target_out(a_tgt), .ret_valid_out(a_vld), .ptr_out(a_ptr),
        .count_out(a_cnt), .overflow_out(a_ovf)
    );

    ras_ckpt #(.RAS_ENTRIES(16)) dut_b (
        .CLK(CLK), .RST(RST),
        .push_valid_in(push_v), .push_target_in(push_t), .pop_valid_in(pop_v),
        .restore_valid_in(rs_v), .restore_ptr_in(rs_ptr), .restore_count_in(rs_cnt),
        .ret_target_out(b_tgt), .ret_valid_out(b_vld), .ptr_out(b_ptr),
        .count_out(b_cnt), .overflow_out(b_ovf)
    );

    // Model: k=0 is the depth-8 stack, k=1 the depth-16 stack.
    logic [30:0] m_mem [2][16];
    int          m_ptr [2];
    int          m_cnt [2];
    bit          m_ov  [2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic mstep(input int k);
        int n;
        int rp;
        int rc;
        n  = (k == 1) ? 16 : 8;
        rp = (k == 1) ? int'(rs_ptr) : int'(rs_ptr[2:0]);
        rc = (k == 1) ? int'(rs_cnt) : int'(rs_cnt[3:0]);
        m_ov[k] = 1'b0;
        if (rs_v) begin
            m_ptr[k] = rp;
            m_cnt[k] = (rc > n) ? n : rc;
        end else if (push_v && pop_v) begin
            m_mem[k][m_ptr[k]] = push_t;
            if (m_cnt[k] == 0) m_cnt[k] = 1;
        end else if (push_v) begin
            if (m_cnt[k] == n) m_ov[k] = 1'b1;
            else m_cnt[k] = m_cnt[k] + 1;
            m_ptr[k] = (m_ptr[k] + 1) % n;
            m_mem[k][m_ptr[k]] = push_t;
        end else if (pop_v) begin
            m_ptr[k] = (m_ptr[k] + n - 1) % n;
            if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
        end
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 2; k++) begin
                m_ptr[k] = 0;
                m_cnt[k] = 0;
                m_ov[k]  = 1'b0;
                for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
            end
        end else begin
            mstep(0);
            mstep(1);
        end
    end

    // Single compare process: both instances against the model every cycle.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("a_ptr", a_ptr, m_ptr[0]);
            check("a_cnt", a_cnt, m_cnt[0]);
            check("a_vld", a_vld, m_cnt[0] != 0);
            check("a_tgt", a_tgt, m_mem[0][m_ptr[0]]);
            check("a_ovf", a_ovf, m_ov[0]);
            check("b_ptr", b_ptr, m_ptr[1]);
            check("b_cnt", b_cnt, m_cnt[1]);
            check("b_vld", b_vld, m_cnt[1] != 0);
            check("b_tgt", b_tgt, m_mem[1][m_ptr[1]]);
            check("b_ovf", b_ovf, m_ov[1]);
        end
    end

    task automatic op(input bit pu, input bit po, input logic [30:0] t);
        push_v = pu;
        pop_v  = po;
        push_t = t;
        rs_v   = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        push_v = 1'b0;
        pop_v  = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    ras_ckpt_t ck;

    initial begin
        repeat (2) @(negedge CLK);
        RST    = 1'b0;
        chk_en = 1'b1;
        check("rst_ptr", a_ptr, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_vld", a_vld, 0);
        check("rst_tgt", a_tgt, 0);

        // LIFO order
        op(1, 0, 31'h100);
        op(1, 0, 31'h200);
        op(1, 0, 31'h300);
        check("lifo_cnt3", a_cnt, 3);
        check("lifo_top300", a_tgt, 31'h300);
        op(0, 1, '0);
        check("lifo_top200", a_tgt, 31'h200);
        op(0, 1, '0);
        check("lifo_top100", a_tgt, 31'h100);
        op(0, 1, '0);
        check("lifo_cnt0", a_cnt, 0);
        check("lifo_vld0", a_vld, 0);

        // Reset asserted mid-stream acts without waiting for a clock edge
        op(1, 0, 31'h55);
        #2 RST = 1'b1;
        #1;
        check("mid_rst_ptr", a_ptr, 0);
        check("mid_rst_cnt", a_cnt, 0);
        check("mid_rst_vld", a_vld, 0);
        check("mid_rst_tgt", a_tgt, 0);
        @(negedge CLK);
        RST = 1'b0;

        // Overflow at depth 8
        for (int i = 1; i <= 8; i++) op(1, 0, 31'(i));
        check("ovf_pre", a_ovf, 0);
        check("ovf_cnt8", a_cnt, 8);
        op(1, 0, 31'h9);
        check("ovf_pulse", a_ovf, 1);
        check("ovf_cnt_sat", a_cnt, 8);
        op(0, 0, '0);
        check("ovf_clear", a_ovf, 0);
        for (int i = 0; i < 8; i++) begin
            check("ovf_pop_tgt", a_tgt, 31'(9 - i));
            op(0, 1, '0);
        end
        check("ovf_drained", a_cnt, 0);

        // Underflow from a clean reset
        pulse_reset();
        op(0, 1, '0);
        check("unf_ptr7", a_ptr, 7);
        check("unf_cnt0", a_cnt, 0);
        check("unf_vld0", a_vld, 0);
        check("unf_tgt_noX", a_tgt, 0);

        // Pop+push replaces the top
        op(1, 0, 31'hA);
        op(1, 0, 31'hB);
        op(1, 1, 31'hC);
        check("pp_top", a_tgt, 31'hC);
        check("pp_cnt", a_cnt, 2);
        check("pp_ptr", a_ptr, 1);
        op(0, 1, '0);
        check("pp_pop_top", a_tgt, 31'hA);

        // Checkpoint (ptr=2, count=3), wander, then restore alongside a push
        pulse_reset();
        op(0, 1, '0);
        op(1, 0, 31'h11);
        op(1, 0, 31'h22);
        op(1, 0, 31'h33);
        ck.ptr   = 3'd2;
        ck.count = 4'd3;
        op(1, 0, 31'h44);
        op(1, 0, 31'h55);
        for (int i = 0; i < 4; i++) op(0, 1, '0);
        rs_ptr = {1'b0, ck.ptr};
        rs_cnt = {1'b0, ck.count};
        rs_v   = 1'b1;
        push_v = 1'b1;
        push_t = 31'h66;
        @(posedge CLK);
        @(negedge CLK);
        rs_v   = 1'b0;
        push_v = 1'b0;
        check("rs_ptr", a_ptr, 2);
        check("rs_cnt", a_cnt, 3);
        check("rs_tgt", a_tgt, 31'h33);
        check("rs_vld", a_vld, 1);

        // Restore count above depth clamps to full
        rs_ptr = 4'd5;
        rs_cnt = 5'd15;
        rs_v   = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        rs_v = 1'b0;
        check("rs_clamp_cnt", a_cnt, 8);
        check("rs_clamp_ptr", a_ptr, 5);

        // Random traffic on both depths
        for (int c = 0; c < 10000; c++) begin
            int r;
            r      = int'($urandom_range(0, 99));
            rs_v   = (r < 4);
            push_v = (r >= 4 && r < 55) || (r >= 90);
            pop_v  = (r >= 50);
            push_t = 31'($urandom);
            rs_ptr = 4'($urandom);
            rs_cnt = 5'($urandom);
            @(posedge CLK);
            @(negedge CLK);
        end
        rs_v   = 1'b0;
        push_v = 1'b0;
        pop_v  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
